// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// opcode/funct constants, ALU control codes and PC source selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  // Map an R-type function field to {legal, alu_code}; illegal codes give 0.
  function automatic logic [3:0] decode_funct(input logic [5:0] fn);
    logic [3:0] r;
    r = 4'b0000;
    case (fn)
      FN_ADD:  r = {1'b1, ALU_ADD};
      FN_SUB:  r = {1'b1, ALU_SUB};
      FN_AND:  r = {1'b1, ALU_AND};
      FN_OR:   r = {1'b1, ALU_OR};
      FN_SLT:  r = {1'b1, ALU_SLT};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait watchdog. Counts consecutive not-ready cycles while the
// controller sits in a memory-wait state and flags expiry on the
// TIMEOUT_CYCLES-th such cycle. The count returns to zero whenever the
// controller is not waiting, memory responds, or the timer expires, so it
// is always zero on entry to a wait state.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic wait_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q, count_d;

  // Expiry: this cycle is the TIMEOUT_CYCLES-th stall and memory is still not ready.
  assign expire_o = wait_i && !ready_i && (count_q == LAST_COUNT);

  // Next count: advance on a stall, otherwise restart from zero.
  always_comb begin
    count_d = count_q + 8'd1;
    if (!wait_i || ready_i || expire_o) count_d = 8'd0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= 8'd0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM whose outputs decode the
// current state; only the FETCH write strobes and the MEMWR strobe look at
// mem_ready/timeout. Memory waits are bounded by mem_wait_timer.
// Optional trap handling is enabled with the MC_CTRL_TRAP_EN macro; without
// it, illegal instructions and bus errors return to FETCH silently.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ALUOP_W        = 3
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic [5:0]         Func,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               Branch,
  output logic               BranchNe,
  output logic               PCWrite,
  output logic               ExtOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] AluOP,
  output logic               jump,
  output logic               bus_err,
  output logic               illegal,
  output logic [3:0]         state_o
);

`ifdef MC_CTRL_TRAP_EN
  localparam state_t FAULT_STATE = S_TRAP;
`else
  localparam state_t FAULT_STATE = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic       in_wait;
  logic       expire;
  logic [3:0] funct_dec;
  logic [2:0] alu_code;

`ifdef MC_CTRL_TRAP_EN
  // Remembers whether the previous cycle was a bus error, i.e. why TRAP was entered.
  logic trap_bus_q, trap_bus_d;
  assign trap_bus_d = expire;
`endif

  assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign funct_dec = decode_funct(Func);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (CLK),
    .reset_i  (reset),
    .wait_i   (in_wait),
    .ready_i  (mem_ready),
    .expire_o (expire)
  );

  // Next-state selection; a timeout wins over staying, mem_ready wins over a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (expire)         state_d = FAULT_STATE;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (OP)
          OP_RTYPE:                state_d = S_EXEC;
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_J:                    state_d = S_JUMP;
          default:                 state_d = FAULT_STATE;
        endcase
      end
      S_MEMADR: state_d = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (expire)         state_d = FAULT_STATE;
        else if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (expire)         state_d = FAULT_STATE;
        else if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC:   state_d = funct_dec[3] ? S_ALUWB : FAULT_STATE;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_TRAP_EN
      S_TRAP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset overrides every transition.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_FETCH;
`ifdef MC_CTRL_TRAP_EN
      trap_bus_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MC_CTRL_TRAP_EN
      trap_bus_q <= trap_bus_d;
`endif
    end
  end

  // Output decode of the current state; anything not set here stays 0.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    PCWrite  = 1'b0;
    ExtOp    = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = PCSRC_ALU;
    alu_code = 3'b000;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        alu_code = ALU_ADD;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB  = 2'b11;
        alu_code = ALU_ADD;
      end
      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        ExtOp    = 1'b1;
        alu_code = ALU_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = !expire;
      end
      S_EXEC: begin
        ALUSrcA  = 1'b1;
        alu_code = funct_dec[2:0];
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_code = ALU_SUB;
        PCSrc    = PCSRC_ALUOUT;
        Branch   = 1'b1;
        BranchNe = (OP == OP_BNE);
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OP)
          OP_ADDI: begin
            alu_code = ALU_ADD;
            ExtOp    = 1'b1;
          end
          OP_ANDI: alu_code = ALU_AND;
          OP_ORI:  alu_code = ALU_OR;
          default: alu_code = 3'b000;
        endcase
      end
      S_IWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
`ifdef MC_CTRL_TRAP_EN
      S_TRAP: begin
        PCSrc   = PCSRC_TRAP;
        PCWrite = 1'b1;
        illegal = !trap_bus_q;
      end
`endif
      default: begin
        IorD = 1'b0;
      end
    endcase
  end

  assign AluOP   = ALUOP_W'(alu_code);
  assign jump    = (PCSrc == PCSRC_JUMP);
  assign bus_err = expire;
  assign state_o = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum mem_ready wait cycles before bus error (legal range 1..255).
REQ-002 Parameter ALUOP_W, default 3: width of AluOP.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 OP  in  6  instruction opcode. Func  in  6  R-type function field.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, BranchNe, PCWrite, ExtOp  out  1 each  datapath controls; ExtOp=1 sign-extend, 0 zero-extend.
REQ-008 ALUSrcB  out  2  B-operand select. PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 trap vector.
REQ-009 AluOP  out  ALUOP_W  ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 jump  out  1  equals (PCSrc==10). bus_err  out  1  one-cycle pulse. illegal  out  1  one-cycle pulse. state_o  out  4  current state.

Function
REQ-011 Moore FSM; all outputs decode state only, except IRWrite/PCWrite in FETCH and MemWrite-completion, which are qualified by mem_ready.
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IEXEC, IWB, JUMP, TRAP.
REQ-013 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00; IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then DECODE.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, add; next by OP: 000000 EXEC, 100011/101011 MEMADR, 000100/000101 BRANCH, 001000/001100/001101 IEXEC, 000010 JUMP, other TRAP.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, add; next MEMRD if lw, MEMWR if sw.
REQ-016 MEMRD: IorD=1; hold until mem_ready, then MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-017 MEMWR: IorD=1, MemWrite=1 held every cycle in state; on mem_ready next FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00; AluOP from Func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other Func -> TRAP, else ALUWB.
REQ-019 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1, BranchNe=(OP==000101); next FETCH.
REQ-021 IEXEC: ALUSrcA=1, ALUSrcB=10; addi add/ExtOp=1, andi and/ExtOp=0, ori or/ExtOp=0; next IWB. IWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-022 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-023 Wait counter: clears on entry to FETCH/MEMRD/MEMWR and on mem_ready; increments each cycle in those states with mem_ready=0.
REQ-024 Counter reaching TIMEOUT_CYCLES with mem_ready=0: bus_err=1 for that cycle, no write strobe, next TRAP (FETCH if trap disabled); mem_ready=1 in same cycle wins, no error.
REQ-025 All unlisted outputs are 0 in every state; unreachable encodings go to FETCH.

Reset
REQ-026 reset=1 at any edge, including mid-wait: state FETCH, counter 0, bus_err=illegal=0; outputs then show FETCH decode.
REQ-027 reset has priority over mem_ready and all transitions.

Configuration
REQ-028 MC_CTRL_TRAP_EN defined: TRAP drives PCSrc=11, PCWrite=1, illegal=1 (0 on bus-error entry), then FETCH.
REQ-029 MC_CTRL_TRAP_EN undefined: TRAP state absent; illegal OP/Func go to FETCH silently, illegal tied 0, PCSrc never 11.

Structure
REQ-030 Package mc_ctrl_pkg holds state encodings, opcode/funct constants, AluOP codes, PCSrc codes.
REQ-031 Sub-module mem_wait_timer (parameter TIMEOUT_CYCLES) implements REQ-023/024 counter and expiry flag.

Verification
REQ-032 lw (OP=100011), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5.
REQ-033 sw, mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, FETCH next, bus_err=0.
REQ-034 Fetch with mem_ready=0 for 15 cycles, TIMEOUT_CYCLES=15 -> bus_err pulse once, IRWrite never 1, state TRAP (trap on).
REQ-035 OP=111111 with trap on -> TRAP, PCSrc=11, illegal=1 one cycle; trap off -> FETCH, illegal=0.
REQ-036 bne (OP=000101) -> BRANCH with AluOP=110, Branch=1, BranchNe=1; ori -> ExtOp=0, AluOP=001.
REQ-037 reset asserted during MEMRD wait -> next state FETCH, counter 0, no RegWrite.
